// File: rtl/mpadd_seq.sv
// Multi-word add/subtract that sequences NUM_WORDS word additions through one
// external pipelined adder and chains the carry between words.
module mpadd_seq #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_WORDS   = 4,
    parameter int unsigned ADD_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  op_a,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  op_b,
    input  logic                             op_cin,
    input  logic                             op_sub,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*NUM_WORDS-1:0]  result,
    output logic                             result_cout,
    output logic [DATA_WIDTH-1:0]            add_a,
    output logic [DATA_WIDTH-1:0]            add_b,
    output logic                             add_cin,
    input  logic [DATA_WIDTH-1:0]            add_sum,
    input  logic                             add_cout
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ADD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] a_q;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] b_q;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] res_q;
    logic [IDX_W-1:0]                     idx;
    logic [CNT_W-1:0]                     wait_cnt;
    logic                                 carry;
    logic                                 last_word;

    assign last_word = (idx == LAST_IDX);
    assign result    = res_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = (ADD_LATENCY > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                if (wait_cnt == CNT_W'(1)) begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nx = last_word ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode; the adder sees nonzero operands only while issuing
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_ISSUE: begin
                add_a   = a_q[idx];
                add_b   = b_q[idx];
                add_cin = carry;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, word sequencing and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            carry       <= 1'b0;
            result_cout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_sub ? ~op_b : op_b;
                        carry <= op_sub ? 1'b1 : op_cin;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_CAPTURE: begin
                    res_q[idx] <= add_sum;
                    carry      <= add_cout;
                    if (last_word) begin
                        idx         <= '0;
                        result_cout <= add_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq with a two-register-stage word adder on add_*.
module tb_mpadd_seq;

    localparam int unsigned DW      = 16;
    localparam int unsigned NW      = 4;
    localparam int unsigned LAT     = 2;
    localparam int unsigned W       = DW * NW;
    localparam int unsigned DONE_AT = NW * (LAT + 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
    logic          op_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          result_cout;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic          add_cin;
    logic [DW-1:0] add_sum;
    logic          add_cout;

    logic [DW:0]   stage1;
    logic [DW:0]   stage2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpadd_seq #(
        .DATA_WIDTH  (DW),
        .NUM_WORDS   (NW),
        .ADD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .op_sub      (op_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_cout (result_cout),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout)
    );

    // External adder: two register stages
    always @(posedge clk) begin
        stage1 <= (DW+1)'(add_a) + (DW+1)'(add_b) + (DW+1)'(add_cin);
        stage2 <= stage1;
    end
    assign add_sum  = stage2[DW-1:0];
    assign add_cout = stage2[DW];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_sub   = sub;
        check($sformatf("%s:in_ready_before", tag), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        in_valid = 1'b0;
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
        op_cin   = 1'(($urandom));
        op_sub   = 1'(($urandom));
    endtask

    // Follows one operation cycle by cycle from the accept edge up to DONE
    task automatic track_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] exp_res, input logic exp_cout,
                            input string tag);
        logic [W-1:0] bx;
        logic         c;
        logic [DW:0]  t;
        int           w;
        bx = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        for (int k = 1; k <= int'(DONE_AT); k++) begin
            @(negedge clk);
            check($sformatf("%s:in_ready@%0d", tag, k), 64'(in_ready), 64'd0);
            check($sformatf("%s:out_valid@%0d", tag, k), 64'(out_valid),
                  64'(k == int'(DONE_AT)));
            if (k < int'(DONE_AT) && ((k - 1) % int'(LAT + 1)) == 0) begin
                w = (k - 1) / int'(LAT + 1);
                check($sformatf("%s:add_a@%0d", tag, k), 64'(add_a), 64'(a[w*DW +: DW]));
                check($sformatf("%s:add_b@%0d", tag, k), 64'(add_b), 64'(bx[w*DW +: DW]));
                check($sformatf("%s:add_cin@%0d", tag, k), 64'(add_cin), 64'(c));
                t = (DW+1)'(a[w*DW +: DW]) + (DW+1)'(bx[w*DW +: DW]) + (DW+1)'(c);
                c = t[DW];
            end else begin
                check($sformatf("%s:add_idle@%0d", tag, k),
                      {31'd0, add_cin, add_b, add_a}, 64'd0);
            end
        end
        check($sformatf("%s:result", tag), result, exp_res);
        check($sformatf("%s:cout", tag), 64'(result_cout), 64'(exp_cout));
    endtask

    // Holds DONE for some cycles, then completes the output handshake
    task automatic release_op(input int hold, input logic [W-1:0] exp_res,
                              input logic exp_cout, input string tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s:hold_valid@%0d", tag, h), 64'(out_valid), 64'd1);
            check($sformatf("%s:hold_ready@%0d", tag, h), 64'(in_ready), 64'd0);
            check($sformatf("%s:hold_result@%0d", tag, h), result, exp_res);
            check($sformatf("%s:hold_cout@%0d", tag, h), 64'(result_cout), 64'(exp_cout));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s:idle_valid", tag), 64'(out_valid), 64'd0);
        check($sformatf("%s:idle_ready", tag), 64'(in_ready), 64'd1);
        check($sformatf("%s:idle_result", tag), result, exp_res);
        check($sformatf("%s:idle_cout", tag), 64'(result_cout), 64'(exp_cout));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:in_ready", 64'(in_ready), 64'd1);
        check("rst:out_valid", 64'(out_valid), 64'd0);
        check("rst:result", result, 64'd0);
        check("rst:cout", 64'(result_cout), 64'd0);
        check("rst:add", {31'd0, add_cin, add_b, add_a}, 64'd0);
        rst = 1'b0;

        // Word-0 carry into word 1, with 5 cycles of back-pressure
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, "inc");
        scramble();
        track_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                 64'h0000_0000_0001_0000, 1'b0, "inc");
        release_op(5, 64'h0000_0000_0001_0000, 1'b0, "inc");

        // Carry-in ripples through every word
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, "ripple");
        scramble();
        track_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, "ripple");
        release_op(0, 64'h0, 1'b1, "ripple");

        // Subtract with borrow; op_cin=1 must be ignored
        start_op(64'd5, 64'd7, 1'b1, 1'b1, "sub_neg");
        scramble();
        track_op(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub_neg");
        release_op(1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub_neg");

        start_op(64'd7, 64'd5, 1'b0, 1'b1, "sub_pos");
        scramble();
        track_op(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, "sub_pos");
        release_op(0, 64'd2, 1'b1, "sub_pos");

        // Every word generates a carry
        start_op(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0, 1'b0, "msb");
        scramble();
        track_op(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0, 1'b0,
                 64'h0001_0001_0001_0000, 1'b1, "msb");
        release_op(0, 64'h0001_0001_0001_0000, 1'b1, "msb");

        // Reset during the WAIT of word 2
        start_op(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0, "abort");
        scramble();
        for (int k = 1; k <= 2 * int'(LAT + 1) + 2; k++) @(negedge clk);
        check("abort:partial", 64'(result[31:0]), 64'h2222_2222);
        rst = 1'b1;
        @(negedge clk);
        check("abort:out_valid", 64'(out_valid), 64'd0);
        check("abort:in_ready", 64'(in_ready), 64'd1);
        check("abort:result", result, 64'd0);
        check("abort:cout", 64'(result_cout), 64'd0);
        rst = 1'b0;
        start_op(64'd1, 64'd1, 1'b0, 1'b0, "post");
        scramble();
        track_op(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, "post");
        release_op(0, 64'd2, 1'b0, "post");

        // Back-to-back with in_valid held high and the second op already presented
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, "b2b1");
        op_a   = 64'h0000_0000_0001_0000;
        op_b   = 64'h1;
        op_cin = 1'b0;
        op_sub = 1'b1;
        track_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                 64'h1234_5678_9ABC_DF00, 1'b0, "b2b1");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b:gap_in_ready", 64'(in_ready), 64'd1);
        check("b2b:gap_out_valid", 64'(out_valid), 64'd0);
        check("b2b:gap_result", result, 64'h1234_5678_9ABC_DF00);
        @(posedge clk);
        #1;
        scramble();
        track_op(64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1,
                 64'h0000_0000_0000_FFFF, 1'b1, "b2b2");
        release_op(0, 64'h0000_0000_0000_FFFF, 1'b1, "b2b2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpadd_seq.md
MPADD_SEQ -- requirements
Module: mpadd_seq

Interface
Parameters:
REQ-001 DATA_WIDTH, 16, width of one word and of the shared adder.
REQ-002 NUM_WORDS, 4, number of words per operand; legal range >= 1.
REQ-003 ADD_LATENCY, 2, cycles from adder inputs presented to add_sum/add_cout valid; legal range >= 1.
Ports (W = DATA_WIDTH*NUM_WORDS):
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand request valid.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 op_a  in  W  operand A, word 0 = bits [DATA_WIDTH-1:0].
REQ-009 op_b  in  W  operand B.
REQ-010 op_cin  in  1  carry-in (ignored when op_sub=1).
REQ-011 op_sub  in  1  1 = compute A-B.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 result  out  W  sum/difference.
REQ-015 result_cout  out  1  final carry; for subtract, 1 = no borrow.
REQ-016 add_a, add_b  out  DATA_WIDTH each  word operands to the shared adder.
REQ-017 add_cin  out  1  carry to the shared adder.
REQ-018 add_sum  in  DATA_WIDTH  adder sum, ADD_LATENCY cycles after inputs.
REQ-019 add_cout  in  1  adder carry-out, same timing as add_sum.

Function
REQ-020 Handshake: a request is accepted in the cycle in_valid & in_ready; in_ready = 1 only in IDLE.
REQ-021 On acceptance, op_a, op_b, op_cin and op_sub are latched; op_b is stored inverted and the initial carry is set to 1 when op_sub = 1.
REQ-022 FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-023 Transitions:
- IDLE->ISSUE on accept.
- ISSUE->WAIT if ADD_LATENCY>1, else ISSUE->CAPTURE.
- WAIT->CAPTURE after ADD_LATENCY-1 WAIT cycles, using a down-counter.
- CAPTURE->ISSUE if words remain, else CAPTURE->DONE.
- DONE->IDLE when out_ready = 1.
REQ-024 In ISSUE for word i, add_a, add_b and add_cin carry latched word i of A, latched word i of (possibly inverted) B, and the running carry; in all other states these outputs are 0.
REQ-025 In CAPTURE, add_sum is written to result word i, add_cout becomes the running carry, and the word index increments.
REQ-026 After the last CAPTURE, result_cout = last add_cout.
REQ-027 Each word takes ADD_LATENCY+1 cycles.
REQ-028 out_valid rises NUM_WORDS*(ADD_LATENCY+1)+1 cycles after the accept cycle (13 for defaults).
REQ-029 out_valid = 1 only in DONE; result and result_cout are held stable while out_valid = 1 and out_ready = 0.
REQ-030 DONE with out_ready = 1 returns to IDLE next cycle; the next request cannot be accepted in the same cycle (in_ready = 0 in DONE).
REQ-031 result and result_cout keep their last values in IDLE until overwritten by the next operation's CAPTUREs.
REQ-032 Word index wraps to 0 on entry to IDLE; NUM_WORDS = 1 performs a single ISSUE/CAPTURE.
REQ-033 Changes to in_valid or op_* after acceptance have no effect on the operation in flight.

Reset
REQ-034 While rst = 1 at a clock edge: state = IDLE; word index, wait counter and running carry = 0; result = 0; result_cout = 0; out_valid = 0.
REQ-035 Combinational outputs during and after reset: in_ready = 1 in IDLE; add_a/add_b/add_cin = 0.
REQ-036 Reset mid-operation (any state) abandons the operation.
REQ-037 Stale adder outputs from an abandoned operation are never captured, because capture occurs only ADD_LATENCY cycles after a fresh ISSUE.

Verification (defaults; bench models the adder as a two-register-stage DATA_WIDTH adder on add_*)
REQ-038 A=0x0000_0000_0000_FFFF, B=0x1, cin=0, sub=0 -> result 0x0000_0000_0001_0000, cout 0, out_valid exactly 13 cycles after accept.
REQ-039 A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> result 0, cout 1; carry observed rippling through all 4 words.
REQ-040 sub=1, A=5, B=7 -> result 0xFFFF_FFFF_FFFF_FFFE, cout 0; A=7, B=5 -> result 2, cout 1.
REQ-041 Back-pressure: out_ready held 0 for 5 cycles in DONE -> out_valid, result and cout stable, in_ready 0; out_ready=1 -> IDLE next cycle, in_ready 1.
REQ-042 rst asserted during WAIT of word 2 -> next cycle IDLE, out_valid 0, result 0; a following op A=1, B=1 yields result 2, cout 0 with no stale word.
REQ-043 Back-to-back: in_valid held 1 with two queued ops -> second accepted only after the DONE handshake; add_* are 0 outside ISSUE throughout.
